// File: rtl/l1_victim_sel.sv
// l1_victim_sel: L1 data-cache allocation victim selector.
// Picks the lowest-index invalid way, otherwise the tree pseudo-LRU way,
// and keeps one PLRU tree per set, updated by mm2 touch events.
module l1_victim_sel #(
  parameter int NUM_SETS = 64,
  parameter int NUM_WAYS = 4,
  parameter int SET_W    = $clog2(NUM_SETS),
  parameter int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_lkup_en_mm1,
  input  logic [SET_W-1:0]         i_set_addr_mm1,
  input  logic [NUM_WAYS-1:0][1:0] i_state_rd_ways_mm2,
  input  logic                     i_touch_en_mm2,
  input  logic [WAY_W-1:0]         i_touch_way_mm2,
  output logic                     o_victim_vld_mm2,
  output logic [WAY_W-1:0]         o_victim_way_mm2,
  output logic                     o_victim_inv_mm2
);

  localparam int         NODES = NUM_WAYS - 1;
  localparam logic [1:0] ST_I  = 2'd0;

  logic [NODES-1:0] r_plru [NUM_SETS];

  logic             r_vldMm2;
  logic [SET_W-1:0] r_setMm2;
  logic [NODES-1:0] r_plruMm2;

  logic             w_touchFire;
  logic [NODES-1:0] w_plruTouched;
  logic [NODES-1:0] w_plruRd;
  logic [WAY_W-1:0] w_treeWay;
  logic [WAY_W-1:0] w_invWay;
  logic             w_anyInv;

  // A touch is only honoured while a lookup actually sits in mm2.
  assign w_touchFire = i_touch_en_mm2 & r_vldMm2;

  // Walk the touched way's path from the root and point every node on it away from that way.
  always_comb begin
    int node;
    w_plruTouched = r_plruMm2;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      w_plruTouched[node] = ~i_touch_way_mm2[WAY_W-1-l];
      node = 2 * node + 1 + int'(i_touch_way_mm2[WAY_W-1-l]);
    end
  end

  // A same-set touch in this cycle forwards its post-touch bits into the mm1 capture.
  assign w_plruRd = (w_touchFire && (r_setMm2 == i_set_addr_mm1)) ? w_plruTouched
                                                                  : r_plru[i_set_addr_mm1];

  // Follow the node bits from the root down to a leaf; the leaf offset is the PLRU way.
  always_comb begin
    int node;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      node = 2 * node + 1 + int'(r_plruMm2[node]);
    end
    w_treeWay = WAY_W'(node - NODES);
  end

  // Scan from the top way down so the lowest-index invalid way wins.
  always_comb begin
    w_anyInv = 1'b0;
    w_invWay = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (i_state_rd_ways_mm2[w] == ST_I) begin
        w_anyInv = 1'b1;
        w_invWay = WAY_W'(w);
      end
    end
  end

  // Per-set PLRU storage: cleared on reset, written back by mm2 touches.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_plru[s] <= '0;
      end
    end else if (w_touchFire) begin
      r_plru[r_setMm2] <= w_plruTouched;
    end
  end

  // mm1 -> mm2 pipeline register: lookup valid, set and that set's PLRU bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vldMm2  <= 1'b0;
      r_setMm2  <= '0;
      r_plruMm2 <= '0;
    end else begin
      r_vldMm2 <= i_lkup_en_mm1;
      if (i_lkup_en_mm1) begin
        r_setMm2  <= i_set_addr_mm1;
        r_plruMm2 <= w_plruRd;
      end
    end
  end

  // Outputs are forced to zero when no lookup is in mm2 so they never float.
  assign o_victim_vld_mm2 = r_vldMm2;
  assign o_victim_way_mm2 = r_vldMm2 ? (w_anyInv ? w_invWay : w_treeWay) : '0;
  assign o_victim_inv_mm2 = r_vldMm2 & w_anyInv;

  // A touch with no lookup in mm2 has no set to update and is a protocol error upstream.
  a_touchNeedsLookup : assert property (@(posedge clk) disable iff (reset)
    i_touch_en_mm2 |-> r_vldMm2);

endmodule

// File: tb/tb_l1_victim_sel.sv
// tb_l1_victim_sel: drives 4-, 8- and 2-way selectors from one shared stimulus
// stream and scoreboards every valid victim against a range-halving tree model.
module tb_l1_victim_sel;

  typedef struct {
    int way;
    bit inv;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             lkEn;
  logic [5:0]       setAddr;
  logic [7:0][1:0]  stAll;
  logic             touchEn;
  logic [2:0]       twAll;

  logic             vv4, vi4, vv8, vi8, vv2, vi2;
  logic [1:0]       vw4;
  logic [2:0]       vw8;
  logic [0:0]       vw2;

  exp_t             q4[$];
  exp_t             q8[$];
  exp_t             q2[$];

  int               testsRun    = 0;
  int               testsFailed = 0;

  bit               mdl [3][64][8];
  bit               prevLk;
  int               pendSet;
  logic [7:0][1:0]  pendStates;

  // Free-running clock.
  always #5 clk = ~clk;

  l1_victim_sel #(.NUM_SETS(64), .NUM_WAYS(4)) dut4 (
    .clk                 (clk),
    .reset               (reset),
    .i_lkup_en_mm1       (lkEn),
    .i_set_addr_mm1      (setAddr),
    .i_state_rd_ways_mm2 (stAll[3:0]),
    .i_touch_en_mm2      (touchEn),
    .i_touch_way_mm2     (twAll[1:0]),
    .o_victim_vld_mm2    (vv4),
    .o_victim_way_mm2    (vw4),
    .o_victim_inv_mm2    (vi4)
  );

  l1_victim_sel #(.NUM_SETS(64), .NUM_WAYS(8)) dut8 (
    .clk                 (clk),
    .reset               (reset),
    .i_lkup_en_mm1       (lkEn),
    .i_set_addr_mm1      (setAddr),
    .i_state_rd_ways_mm2 (stAll),
    .i_touch_en_mm2      (touchEn),
    .i_touch_way_mm2     (twAll),
    .o_victim_vld_mm2    (vv8),
    .o_victim_way_mm2    (vw8),
    .o_victim_inv_mm2    (vi8)
  );

  l1_victim_sel #(.NUM_SETS(64), .NUM_WAYS(2)) dut2 (
    .clk                 (clk),
    .reset               (reset),
    .i_lkup_en_mm1       (lkEn),
    .i_set_addr_mm1      (setAddr),
    .i_state_rd_ways_mm2 (stAll[1:0]),
    .i_touch_en_mm2      (touchEn),
    .i_touch_way_mm2     (twAll[0:0]),
    .o_victim_vld_mm2    (vv2),
    .o_victim_way_mm2    (vw2),
    .o_victim_inv_mm2    (vi2)
  );

  function automatic int nWays(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 8 : 2);
  endfunction

  // Reference victim: first invalid way, else halve the way range by each node bit.
  function automatic exp_t modelVictim(input int k, input int s, input logic [7:0][1:0] st);
    exp_t e;
    int   lo, hi, node, mid;
    e.way = -1;
    e.inv = 1'b0;
    for (int w = 0; w < nWays(k); w++) begin
      if (st[w] == 2'd0 && e.way < 0) begin
        e.way = w;
        e.inv = 1'b1;
      end
    end
    if (!e.inv) begin
      lo = 0; hi = nWays(k); node = 0;
      while (hi - lo > 1) begin
        mid = (lo + hi) / 2;
        if (mdl[k][s][node]) begin lo = mid; node = 2 * node + 2; end
        else                 begin hi = mid; node = 2 * node + 1; end
      end
      e.way = lo;
    end
    return e;
  endfunction

  // Reference touch: every node whose range holds the way points to the other half.
  task automatic modelTouch(input int k, input int s, input int wIn);
    int w, lo, hi, node, mid;
    w = wIn % nWays(k);
    lo = 0; hi = nWays(k); node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin mdl[k][s][node] = 1'b1; hi = mid; node = 2 * node + 1; end
      else         begin mdl[k][s][node] = 1'b0; lo = mid; node = 2 * node + 2; end
    end
  endtask

  function automatic logic [7:0][1:0] mkSt(input int a, input int b, input int c, input int d);
    logic [7:0][1:0] r;
    r = '1;
    r[0] = a[1:0];
    r[1] = b[1:0];
    r[2] = c[1:0];
    r[3] = d[1:0];
    return r;
  endfunction

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pops the oldest expectation for instance k and compares the presented victim.
  task automatic checkOutput(input int k, input logic [31:0] way, input logic inv);
    exp_t  e;
    bit    empty;
    string tag;
    tag = (k == 0) ? "dut4" : ((k == 1) ? "dut8" : "dut2");
    case (k)
      0:       empty = (q4.size() == 0);
      1:       empty = (q8.size() == 0);
      default: empty = (q2.size() == 0);
    endcase
    if (empty) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s unexpected valid: got way %0d, expected no output", tag, way);
    end else begin
      case (k)
        0:       e = q4.pop_front();
        1:       e = q8.pop_front();
        default: e = q2.pop_front();
      endcase
      checkEq({tag, " way"}, way, e.way);
      checkEq({tag, " inv"}, {31'd0, inv}, {31'd0, e.inv});
    end
  endtask

  // One clock of stimulus: mm2 states/touch for the previous lookup plus a new mm1 lookup.
  task automatic applyStimulus(input bit doLk, input int s, input logic [7:0][1:0] lkSt,
                               input bit doTouch, input int tw, input bit doRst,
                               input int expWay4, input int expInv4);
    exp_t e;
    @(posedge clk);
    #1;
    reset   = doRst;
    lkEn    = doLk && !doRst;
    setAddr = s[5:0];
    stAll   = pendStates;
    touchEn = doTouch;
    twAll   = tw[2:0];
    if (doRst) begin
      for (int k = 0; k < 3; k++)
        for (int x = 0; x < 64; x++)
          for (int n = 0; n < 8; n++)
            mdl[k][x][n] = 1'b0;
    end else if (doTouch) begin
      for (int k = 0; k < 3; k++) modelTouch(k, pendSet, tw);
    end
    if (doLk && !doRst) begin
      for (int k = 0; k < 3; k++) begin
        e = modelVictim(k, s, lkSt);
        if (k == 0 && expWay4 >= 0) begin
          e.way = expWay4;
          e.inv = expInv4[0];
        end
        case (k)
          0:       q4.push_back(e);
          1:       q8.push_back(e);
          default: q2.push_back(e);
        endcase
      end
      pendSet    = s;
      pendStates = lkSt;
    end
    prevLk = doLk && !doRst;
  endtask

  // Monitor: checks whatever each instance presents, away from the active edge.
  always @(negedge clk) begin
    if (vv4 === 1'b1) checkOutput(0, {30'd0, vw4}, vi4);
    if (vv8 === 1'b1) checkOutput(1, {29'd0, vw8}, vi8);
    if (vv2 === 1'b1) checkOutput(2, {31'd0, vw2}, vi2);
  end

  // Directed sequence from the test plan, then a random soak, then drain.
  initial begin
    logic [7:0][1:0] allM;
    logic [7:0][1:0] st;
    bit              lk;
    bit              t;
    int              s;

    allM       = '1;
    reset      = 1'b1;
    lkEn       = 1'b0;
    setAddr    = '0;
    stAll      = '1;
    touchEn    = 1'b0;
    twAll      = '0;
    prevLk     = 1'b0;
    pendSet    = 0;
    pendStates = '1;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkEq("reset vld4", {31'd0, vv4}, 0);
    checkEq("reset way4", {30'd0, vw4}, 0);
    checkEq("reset inv4", {31'd0, vi4}, 0);
    checkEq("reset vld8", {31'd0, vv8}, 0);
    checkEq("reset way8", {29'd0, vw8}, 0);
    checkEq("reset inv8", {31'd0, vi8}, 0);
    checkEq("reset vld2", {31'd0, vv2}, 0);
    checkEq("reset way2", {31'd0, vw2}, 0);
    checkEq("reset inv2", {31'd0, vi2}, 0);

    // Full 4-way tree walk on set 5: victims 0, 2, 1, 3.
    applyStimulus(1, 5, allM, 0, 0, 0, 0, 0);
    applyStimulus(1, 5, allM, 1, 0, 0, 2, 0);
    applyStimulus(1, 5, allM, 1, 2, 0, 1, 0);
    applyStimulus(1, 5, allM, 1, 1, 0, 3, 0);
    // Invalid ways override nonzero PLRU bits.
    applyStimulus(1, 5, mkSt(3, 0, 1, 0), 1, 3, 0, 1, 1);
    applyStimulus(1, 5, mkSt(0, 0, 0, 0), 0, 0, 0, 0, 1);
    applyStimulus(0, 0, allM, 0, 0, 0, -1, 0);

    // Same-set bypass on set 9, then a different-set lookup on set 10.
    applyStimulus(1, 9,  allM, 0, 0, 0, 0, 0);
    applyStimulus(1, 9,  allM, 1, 0, 0, 2, 0);
    applyStimulus(1, 9,  allM, 1, 0, 0, 2, 0);
    applyStimulus(1, 10, allM, 1, 0, 0, 0, 0);
    applyStimulus(0, 0,  allM, 0, 0, 0, -1, 0);

    // Reset mid-operation with a touch pending on set 3.
    applyStimulus(1, 3, allM, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, allM, 1, 0, 1, -1, 0);
    applyStimulus(1, 3, allM, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkEq("post-reset vld4", {31'd0, vv4}, 0);
    checkEq("post-reset vld8", {31'd0, vv8}, 0);
    checkEq("post-reset vld2", {31'd0, vv2}, 0);
    applyStimulus(1, 5, allM, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, allM, 0, 0, 0, -1, 0);

    // Random soak with a hot set range to exercise the bypass often.
    for (int i = 0; i < 10000; i++) begin
      lk = ($urandom_range(99) < 85);
      if ($urandom_range(1) == 1) s = $urandom_range(3);
      else                        s = $urandom_range(63);
      if ($urandom_range(1) == 1) begin
        for (int w = 0; w < 8; w++) st[w] = 2'($urandom_range(3, 1));
      end else begin
        st = 16'($urandom);
      end
      t = prevLk && ($urandom_range(99) < 70);
      applyStimulus(lk, s, st, t, $urandom_range(7), 0, -1, 0);
    end

    repeat (3) applyStimulus(0, 0, allM, 0, 0, 0, -1, 0);
    @(negedge clk);
    checkEq("dut4 queue drained", q4.size(), 0);
    checkEq("dut8 queue drained", q8.size(), 0);
    checkEq("dut2 queue drained", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
